// File: rtl/vector_sequencer.sv
// Test-vector sequencer: steps a {a, y_expected} memory through a combinational
// unit, counting mismatches. VECSEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module vector_sequencer #(
  parameter  int WIDTH  = 4,
  parameter  int NVEC   = 16,
  parameter  int SETTLE = 1,
  localparam int AW     = (NVEC > 1) ? $clog2(NVEC) : 1,
  localparam int CW     = $clog2(NVEC + 1),
  localparam int SW     = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH:0]   wr_data,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_cnt,
  output logic [AW-1:0]    fail_idx,
  output logic [AW-1:0]    vec_idx
);

  typedef enum logic [1:0] {IDLE, SETL, CHECK, DONE} state_t;

  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NVEC - 1);
  localparam logic [CW-1:0] ERR_MAX   = CW'(NVEC);

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q;
  logic [WIDTH:0] mem [NVEC];

  logic start_ok, mismatch, last;

  assign busy     = (state_q == SETL) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign pass     = done && (err_cnt == '0);
  assign start_ok = start && !busy;
  assign mismatch = (state_q == CHECK) && (y != mem[vec_idx][0]);
  assign last     = (vec_idx == LAST_IDX);

  // Vector memory survives reset so a self-test can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = SETL;
      SETL:       if (cnt_q == SW'(1)) state_d = CHECK;
      CHECK: begin
`ifdef VECSEQ_STOP_ON_FAIL_EN
        if (mismatch || last) state_d = DONE;
        else                  state_d = SETL;
`else
        if (last) state_d = DONE;
        else      state_d = SETL;
`endif
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      vec_idx  <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_ok) begin
          // A same-cycle write to word 0 must be visible to the run it starts.
          a        <= (wr_en && wr_addr == '0) ? wr_data[WIDTH:1] : mem[0][WIDTH:1];
          vec_idx  <= '0;
          err_cnt  <= '0;
          fail_idx <= '0;
          cnt_q    <= SETTLE_LD;
        end
        SETL: cnt_q <= cnt_q - SW'(1);
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + CW'(1);
            if (err_cnt == '0)      fail_idx <= vec_idx;
          end
          if (state_d == SETL) begin
            vec_idx <= vec_idx + AW'(1);
            a       <= mem[vec_idx + AW'(1)][WIDTH:1];
            cnt_q   <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=3) driving XOR4 reductions.
module tb_vector_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en0 = 1'b0, wr_en1 = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [3:0] a0, a1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [3:0] fail0, fail1, vec0, vec1;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  vector_sequencer #(.WIDTH(4), .NVEC(16), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start0), .a(a0), .y(^a0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_idx(fail0), .vec_idx(vec0));

  vector_sequencer #(.WIDTH(4), .NVEC(16), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start1), .a(a1), .y(^a1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_idx(fail1), .vec_idx(vec1));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] vw(input int k);
    logic [3:0] v;
    v = k[3:0];
    return {v, ^v};
  endfunction

  task automatic wr(input logic e0, input logic e1, input int addr, input logic [4:0] d);
    wr_en0 = e0; wr_en1 = e1; wr_addr = addr[3:0]; wr_data = d;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
  endtask

  task automatic go0();
    start0 = 1'b1; tick(); start0 = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_a", a0, 0);      check("rst_vec", vec0, 0);  check("rst_err", err0, 0);
    check("rst_fail", fail0, 0); check("rst_busy", busy0, 0); check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) wr(1'b1, 1'b1, k, vw(k));

    // All pass: a steps 0..15, done at T0+32
    go0();
    for (int k = 0; k < 16; k++) begin
      check("step_a", a0, k); check("step_vec", vec0, k);
      check("step_busy", busy0, 1); check("step_done", done0, 0);
      tick();
      if (k == 15) check("done_early", done0, 0);
      tick();
    end
    check("p1_done", done0, 1); check("p1_pass", pass0, 1);
    check("p1_err", err0, 0);   check("p1_busy", busy0, 0);

    // Reset mid-run at T0+7, then rerun from preserved memory
    go0();
    repeat (7) tick();
    check("mid_a", a0, 3);
    rst_n = 1'b0; #1;
    check("mr_a", a0, 0);       check("mr_vec", vec0, 0); check("mr_busy", busy0, 0);
    check("mr_done", done0, 0); check("mr_pass", pass0, 0);
    #2 rst_n = 1'b1;
    tick();
    go0();
    repeat (31) tick();
    check("rr_done31", done0, 0);
    tick();
    check("rr_done", done0, 1); check("rr_pass", pass0, 1);
    check("rr_err", err0, 0);   check("rr_a", a0, 15);

    // Two bad vectors (5, 9)
    wr(1'b1, 1'b0, 5, vw(5) ^ 5'b00001);
    wr(1'b1, 1'b0, 9, vw(9) ^ 5'b00001);
    go0();
    repeat (11) tick();
    check("bad_done11", done0, 0);
    tick();
`ifdef VECSEQ_STOP_ON_FAIL_EN
    check("sf_done", done0, 1); check("sf_err", err0, 1); check("sf_fail", fail0, 5);
    check("sf_a", a0, 4'b0101); check("sf_vec", vec0, 5); check("sf_pass", pass0, 0);
    repeat (3) tick();
    check("sf_a_hold", a0, 4'b0101); check("sf_done_hold", done0, 1);
`else
    check("bad_err12", err0, 1); check("bad_fail12", fail0, 5);
    repeat (19) tick();
    check("bad_done31", done0, 0);
    tick();
    check("bad_done", done0, 1); check("bad_err", err0, 2);
    check("bad_fail", fail0, 5); check("bad_pass", pass0, 0);
`endif
    wr(1'b1, 1'b0, 5, vw(5));
    wr(1'b1, 1'b0, 9, vw(9));

    // start and write to addr 3 while busy are ignored
    go0();
    repeat (3) tick();
    start0 = 1'b1; wr_en0 = 1'b1; wr_addr = 4'd3; wr_data = 5'b11110;
    tick();
    start0 = 1'b0; wr_en0 = 1'b0;
    check("ign_a4", a0, 2); check("ign_vec4", vec0, 2);
    tick(); tick();
    check("ign_a6", a0, 3);
    repeat (25) tick();
    check("ign_done31", done0, 0);
    tick();
    check("ign_done", done0, 1); check("ign_pass", pass0, 1);

    // Write and start in the same cycle: run uses the new word 0
    wr_en0 = 1'b1; wr_addr = 4'd0; wr_data = vw(6); start0 = 1'b1;
    tick();
    wr_en0 = 1'b0; start0 = 1'b0;
    check("ws_a", a0, 6);
    repeat (32) tick();
    check("ws_done", done0, 1); check("ws_pass", pass0, 1);
    wr(1'b1, 1'b0, 0, vw(0));

    // SETTLE=3: first y sample at T0+4 (vector 0 made bad to observe it)
    wr(1'b0, 1'b1, 0, vw(0) ^ 5'b00001);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("s3_a0", a1, 0);
    repeat (3) tick();
    check("s3_err3", err1, 0); check("s3_a3", a1, 0);
    tick();
    check("s3_err4", err1, 1); check("s3_fail4", fail1, 0);
`ifdef VECSEQ_STOP_ON_FAIL_EN
    check("s3_sf_done", done1, 1); check("s3_sf_a", a1, 0);
`else
    check("s3_a4", a1, 1);
    repeat (60) tick();
    check("s3b_done", done1, 1); check("s3b_err", err1, 1); check("s3b_pass", pass1, 0);
`endif
    wr(1'b0, 1'b1, 0, vw(0));
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (63) tick();
    check("s3_done63", done1, 0);
    tick();
    check("s3_done", done1, 1); check("s3_pass", pass1, 1); check("s3_a", a1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
